// File: rtl/circle_raster_param.sv
// circle_raster_param: midpoint circle rasteriser with outline and span-fill modes.
// It emits clipped linear frame-buffer addresses on a valid/ready stream.
`default_nettype none

module circle_raster_param #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [XW-1:0]     cx,
    input  logic [YW-1:0]     cy,
    input  logic [XW-1:0]     radius,
    input  logic              fill,
    output logic              busy,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              done
);

    localparam int IW = XW + 3;
    localparam int CW = ((XW > YW) ? XW : YW) + 3;

    typedef logic signed [IW-1:0] int_t;
    typedef logic signed [CW-1:0] crd_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_EMIT = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;
    logic [XW-1:0] cx_q, r_q;
    logic [YW-1:0] cy_q;
    logic          fill_q;
    int_t          x_q, y_q, d_q;
    int_t          x_d, y_d, d_d;
    logic [2:0]    sel_q, sel_d;
    crd_t          pos_q, pos_d;
    logic [CW-1:0] px_q, py_q;
    crd_t          px_d, py_d;
    logic          vis_d, last_w, adv_w;
    logic          busy_q, valid_q, done_q;
    crd_t          w_cx, w_cy, sx, sy;

    assign w_cx = crd_t'(cx_q);
    assign w_cy = crd_t'(cy_q);

    // Outline slot order: four (+-x,+-y) octants, then the four (+-y,+-x) octants.
    function automatic crd_t f_out_px(input logic [2:0] s, input crd_t c, input crd_t x, input crd_t y);
        if (s[2]) return s[0] ? c - y : c + y;
        return s[0] ? c - x : c + x;
    endfunction

    function automatic crd_t f_out_py(input logic [2:0] s, input crd_t c, input crd_t x, input crd_t y);
        if (s[2]) return s[1] ? c - x : c + x;
        return s[1] ? c - y : c + y;
    endfunction

    function automatic crd_t f_row(input logic [1:0] k, input crd_t c, input crd_t x, input crd_t y);
        if (k[1]) return k[0] ? c - x : c + x;
        return k[0] ? c - y : c + y;
    endfunction

    function automatic crd_t f_lo(input logic [1:0] k, input crd_t c, input crd_t x, input crd_t y);
        return k[1] ? c - y : c - x;
    endfunction

    function automatic crd_t f_hi(input logic [1:0] k, input crd_t c, input crd_t x, input crd_t y);
        return k[1] ? c + y : c + x;
    endfunction

    always_comb begin
        x_d = x_q + int_t'(1);
        if (d_q[IW-1]) begin
            d_d = d_q + (x_q <<< 1) + int_t'(3);
            y_d = y_q;
        end else begin
            d_d = d_q + ((x_q - y_q) <<< 1) + int_t'(5);
            y_d = y_q - int_t'(1);
        end

        // The slot to present next depends on where we enter it from.
        sx    = crd_t'(x_q);
        sy    = crd_t'(y_q);
        sel_d = sel_q + 3'd1;
        pos_d = pos_q;
        case (state_q)
            S_INIT: begin
                sx    = '0;
                sy    = crd_t'(r_q);
                sel_d = 3'd0;
                pos_d = w_cx;
            end
            S_STEP: begin
                sx    = crd_t'(x_d);
                sy    = crd_t'(y_d);
                sel_d = 3'd0;
                pos_d = f_lo(2'd0, w_cx, crd_t'(x_d), crd_t'(y_d));
            end
            default: begin
                if (fill_q) begin
                    if (pos_q == f_hi(sel_q[1:0], w_cx, sx, sy)) begin
                        pos_d = f_lo(sel_d[1:0], w_cx, sx, sy);
                    end else begin
                        sel_d = sel_q;
                        pos_d = pos_q + crd_t'(1);
                    end
                end
            end
        endcase

        px_d   = fill_q ? pos_d : f_out_px(sel_d, w_cx, sx, sy);
        py_d   = fill_q ? f_row(sel_d[1:0], w_cy, sx, sy) : f_out_py(sel_d, w_cy, sx, sy);
        vis_d  = !px_d[CW-1] && (px_d < crd_t'(SCREEN_W)) &&
                 !py_d[CW-1] && (py_d < crd_t'(SCREEN_H));
        last_w = fill_q ? ((sel_q[1:0] == 2'd3) &&
                           (pos_q == f_hi(2'd3, w_cx, crd_t'(x_q), crd_t'(y_q))))
                        : (sel_q == 3'd7);
        adv_w  = !valid_q || pix_ready;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            fill_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            sel_q   <= '0;
            pos_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cx_q    <= cx;
                        cy_q    <= cy;
                        r_q     <= radius;
                        fill_q  <= fill;
                        busy_q  <= 1'b1;
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    x_q     <= '0;
                    y_q     <= int_t'(r_q);
                    d_q     <= int_t'(1) - int_t'(r_q);
                    sel_q   <= sel_d;
                    pos_q   <= pos_d;
                    px_q    <= px_d;
                    py_q    <= py_d;
                    valid_q <= vis_d;
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (adv_w) begin
                        if (last_w) begin
                            valid_q <= 1'b0;
                            state_q <= S_STEP;
                        end else begin
                            sel_q   <= sel_d;
                            pos_q   <= pos_d;
                            px_q    <= px_d;
                            py_q    <= py_d;
                            valid_q <= vis_d;
                        end
                    end
                end
                S_STEP: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    d_q <= d_d;
                    if (x_d <= y_d) begin
                        sel_q   <= sel_d;
                        pos_q   <= pos_d;
                        px_q    <= px_d;
                        py_q    <= py_d;
                        valid_q <= vis_d;
                        state_q <= S_EMIT;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign pix_valid = valid_q;
    assign done      = done_q;
    assign pix_addr  = ADDR_W'(py_q) * ADDR_W'(SCREEN_W) + ADDR_W'(px_q);

endmodule

`default_nettype wire

// File: tb/tb_circle_raster_param.sv
// Self-checking bench for circle_raster_param: a plain midpoint-circle model feeds
// an expected-address queue that one monitor process compares against every handshake.
`default_nettype none

module tb_circle_raster_param;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic [9:0]  radius;
    logic        fill;
    logic        busy, pix_valid, pix_ready, done;
    logic [18:0] pix_addr;

    always #5 clk = ~clk;

    circle_raster_param dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .cx        (cx),
        .cy        (cy),
        .radius    (radius),
        .fill      (fill),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_addr  (pix_addr),
        .done      (done)
    );

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int nslots, nsteps;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit prev_stall = 1'b0;
    int prev_addr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_slot(input int px, input int py);
        nslots++;
        if (px >= 0 && px < 640 && py >= 0 && py < 480) exp_q.push_back(py * 640 + px);
    endtask

    // Straight transcription of the midpoint algorithm, producing every slot in order.
    task automatic model(input int mcx, input int mcy, input int r, input bit f);
        int x, y, d;
        int px[8], py[8], rows[4], hw[4];
        nslots = 0;
        nsteps = 0;
        x = 0; y = r; d = 1 - r;
        do begin
            if (!f) begin
                px = '{mcx+x, mcx-x, mcx+x, mcx-x, mcx+y, mcx-y, mcx+y, mcx-y};
                py = '{mcy+y, mcy+y, mcy-y, mcy-y, mcy+x, mcy+x, mcy-x, mcy-x};
                for (int k = 0; k < 8; k++) push_slot(px[k], py[k]);
            end else begin
                rows = '{mcy+y, mcy-y, mcy+x, mcy-x};
                hw   = '{x, x, y, y};
                for (int k = 0; k < 4; k++)
                    for (int p = mcx - hw[k]; p <= mcx + hw[k]; p++) push_slot(p, rows[k]);
            end
            nsteps++;
            if (d < 0) d += 2*x + 3;
            else begin
                d += 2*(x - y) + 5;
                y--;
            end
            x++;
        end while (x <= y);
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (prev_stall) chk("stall_hold", pix_valid ? int'(pix_addr) : -1, prev_addr);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) chk("extra_pixel", int'(pix_addr), -1);
                else chk("pix_addr", int'(pix_addr), exp_q.pop_front());
            end
            prev_stall = pix_valid && !pix_ready;
            prev_addr  = int'(pix_addr);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run(input int rcx, input int rcy, input int r, input bit f,
                       input bit toggle, input int exp_busy, input bit poke);
        int d0;
        exp_q.delete();
        model(rcx, rcy, r, f);
        if (exp_busy == -2) exp_busy = 2 + nslots + nsteps;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        cx = rcx[9:0]; cy = rcy[8:0]; radius = r[9:0]; fill = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0;
        d0 = done_cnt;
        if (poke) begin
            cx = cx + 10'd7; radius = radius + 10'd3; fill = ~f; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            if (toggle) pix_ready = ~pix_ready;
        end
        chk("done_pulses", done_cnt - d0, 1);
        @(posedge clk); #1;
        chk("busy_after_done", int'(busy), 0);
        chk("leftover_pixels", exp_q.size(), 0);
        if (exp_busy >= 0) chk("busy_cycles", busy_cnt, exp_busy);
        pix_ready = 1'b1;
    endtask

    task automatic pin(input string name, input int mcx, input int mcy, input int r,
                       input bit f, input int lit[8], input int lit_n, input int lit_slots);
        exp_q.delete();
        model(mcx, mcy, r, f);
        chk({name, "_count"}, exp_q.size(), lit_n);
        chk({name, "_slots"}, nslots, lit_slots);
        for (int k = 0; k < lit_n && k < exp_q.size(); k++) chk(name, exp_q[k], lit[k]);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        n_rst = 1'b0; start = 1'b0; cx = '0; cy = '0; radius = '0; fill = 1'b0; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(pix_addr), 0);
        n_rst = 1'b1;

        pin("pin_outline_r1", 10, 10, 1, 1'b0, '{7050, 7050, 5770, 5770, 6411, 6409, 6411, 6409}, 8, 8);
        pin("pin_clip", 0, 0, 1, 1'b0, '{640, 640, 1, 1, 0, 0, 0, 0}, 4, 8);
        pin("pin_fill_r1", 10, 10, 1, 1'b1, '{7050, 5770, 6409, 6410, 6411, 6409, 6410, 6411}, 8, 8);

        run(100, 50, 0, 1'b0, 1'b0, 11, 1'b0);
        run(10, 10, 1, 1'b0, 1'b0, -2, 1'b1);
        run(0, 0, 1, 1'b0, 1'b0, -2, 1'b0);
        run(320, 240, 5, 1'b0, 1'b0, -2, 1'b0);
        run(320, 240, 5, 1'b0, 1'b1, -1, 1'b0);
        run(10, 10, 1, 1'b1, 1'b0, -2, 1'b0);
        run(2, 1, 4, 1'b1, 1'b1, -1, 1'b0);
        run(636, 477, 6, 1'b0, 1'b0, -2, 1'b0);
        run(100, 50, 0, 1'b1, 1'b0, -2, 1'b0);

        // Abort a fill in flight with an asynchronous reset.
        exp_q.delete();
        model(100, 100, 20, 1'b1);
        @(posedge clk); #1;
        cx = 10'd100; cy = 9'd100; radius = 10'd20; fill = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        chk("midfill_busy_before", int'(busy), 1);
        n_rst = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(pix_valid), 0);
        chk("abort_done", int'(done), 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_busy", int'(busy), 0);
        run(10, 10, 1, 1'b0, 1'b0, -2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/circle_raster_param.md
Name: circle_raster_param

Overview:
- Parametrised successor to the single-mode circle rasteriser.
- Takes a centre and radius and walks the midpoint (Bresenham) circle algorithm.
- Emits linear frame-buffer pixel addresses through a valid/ready stream, with screen clipping and backpressure.
- Supports two modes: outline and solid fill (horizontal spans). It sits between the primitive decoder and the frame-buffer write arbiter.

Parameters:
- SCREEN_W, 640, pixels per row; address = py*SCREEN_W + px.
- SCREEN_H, 480, rows.
- XW, 10, width of cx and radius.
- YW, 9, width of cy.
- ADDR_W, 19, pix_addr width; must be >= clog2(SCREEN_W*SCREEN_H).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only when busy=0.
- cx  in  XW  centre x, unsigned.
- cy  in  YW  centre y, unsigned.
- radius  in  XW  radius, unsigned.
- fill  in  1  0 = outline, 1 = filled disc; latched with start.
- busy  out  1  high from the cycle after an accepted start until done.
- pix_valid  out  1  pix_addr holds a valid on-screen pixel.
- pix_ready  in  1  downstream accepts when pix_valid & pix_ready.
- pix_addr  out  ADDR_W  linear pixel address.
- done  out  1  one-cycle pulse after the final slot of a primitive.

Behaviour:
- Reset: busy, pix_valid and done are 0; pix_addr is 0; FSM is in IDLE. Assertion mid-primitive aborts it immediately; no done pulse is produced.
- FSM states: IDLE, INIT, EMIT, STEP, DONE.
- IDLE: start=1 latches cx, cy, radius and fill, then moves to INIT. start while busy is ignored.
- INIT (1 cycle): x=0, y=radius, d=1-radius. Internal arithmetic is signed, XW+3 bits, so no overflow is possible.
- EMIT, outline mode: 8 slots, one per cycle, in this fixed order:
  (cx+x,cy+y), (cx-x,cy+y), (cx+x,cy-y), (cx-x,cy-y), (cx+y,cy+x), (cx-y,cy+x), (cx+y,cy-x), (cx-y,cy-x).
- EMIT, fill mode: 4 spans, in this order:
  - row cy+y, px cx-x..cx+x ascending;
  - row cy-y, same range;
  - row cy+x, px cx-y..cx+y;
  - row cy-x, same range.
  Each pixel is one slot.
- Clipping: a slot with px<0, px>=SCREEN_W, py<0 or py>=SCREEN_H gets pix_valid=0 and still consumes exactly one cycle; no address is emitted for it.
- Backpressure: a slot with pix_valid=1 and pix_ready=0 holds. pix_addr and pix_valid stay stable and no state advances. Deassertion of pix_valid without a handshake is forbidden.
- Duplicates (x=0, x=y, overlapping spans) are emitted as-is; no suppression.
- STEP (1 cycle, pix_valid=0):
  - if d<0, then d += 2x+3;
  - else d += 2(x-y)+5 and y -= 1;
  - then x += 1.
  - If the new x <= y, go to EMIT; otherwise go to DONE.
- DONE: done=1 for one cycle, busy goes to 0, then IDLE. A start in the DONE cycle is ignored; the next start is accepted from IDLE.
- Latency:
  - start to first slot: 2 cycles (INIT, then EMIT).
  - Outline, no stalls: each step takes 9 cycles (8 slots + STEP).
- radius=0 is legal: one step, x=y=0. Outline gives 8 slots at the centre; fill gives 4 one-pixel spans.
- pix_addr is computed from registered px/py. The multiply by SCREEN_W may be a constant multiply or shift-add, and must close timing in one cycle.

Test Plan:
- Reset mid-fill: assert n_rst=0 while busy=1, release -> busy=0, pix_valid=0, done=0, FSM in IDLE, no done pulse; a fresh start afterwards behaves normally.
- Outline, cx=100, cy=50, radius=0, pix_ready=1 -> 8 handshakes all at pix_addr=32100, then done one cycle after STEP; busy high for 11 cycles.
- Outline, cx=10, cy=10, radius=1 -> addresses in order 7050, 7050, 5770, 5770, 6411, 6409, 6411, 6409, then done; there is exactly one step (x=1 > y=0 after STEP).
- Clipping, cx=0, cy=0, radius=1, outline -> slots (-1,0) and (0,-1) give pix_valid=0. The valid sequence is 640, 640, 1, 1, with a total slot count of 8.
- Backpressure, radius=5 outline at (320,240) with pix_ready toggling 1/0 every cycle -> emitted sequence identical to the pix_ready=1 run; pix_addr stable during every stalled cycle.
- Fill, cx=10, cy=10, radius=1 -> spans rows 11 (px 10), 9 (px 10), 10 (px 9..11), 10 (px 9..11). That is 8 addresses: 7050, 5770, 6409, 6410, 6411, 6409, 6410, 6411, then done.
